// File: rtl/cpu_sequencer.sv
// Eight-phase fetch/execute sequencer for the 8-bit accumulator CPU.
// Decodes phase, opcode, zero flag and halted state into the datapath strobes.
//
// phase | meaning
// ------+-------------------------------------------------------------
//   0   | INST_ADDR  : PC drives the address bus
//   1   | INST_FETCH : instruction read, may stall on mem_ready
//   2   | INST_LOAD  : instruction register loads
//   3   | IDLE       : IR settles; opcode is stable from here on
//   4   | OP_ADDR    : PC increments, or HLT stops the sequencer here
//   5   | OP_FETCH   : operand read for ALU ops, may stall on mem_ready
//   6   | ALU_OP     : SKZ skip, JMP load, STO drives the data bus
//   7   | STORE      : accumulator load, or memory write for STO
module cpu_sequencer #(
   parameter int opc_width   = 3,
   parameter bit mem_wait_en = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [opc_width-1:0] opcode,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 sel,
   output logic                 rd,
   output logic                 ld_ir,
   output logic                 inc_pc,
   output logic                 ld_pc,
   output logic                 ld_ac,
   output logic                 wr,
   output logic                 data_e,
   output logic                 halt,
   output logic [2:0]           phase
);

   typedef enum logic [2:0] {
      PH_INST_ADDR  = 3'd0,
      PH_INST_FETCH = 3'd1,
      PH_INST_LOAD  = 3'd2,
      PH_IDLE       = 3'd3,
      PH_OP_ADDR    = 3'd4,
      PH_OP_FETCH   = 3'd5,
      PH_ALU_OP     = 3'd6,
      PH_STORE      = 3'd7
   } phase_e;

   localparam logic [opc_width-1:0] OPC_HLT = opc_width'(0);
   localparam logic [opc_width-1:0] OPC_SKZ = opc_width'(1);
   localparam logic [opc_width-1:0] OPC_ADD = opc_width'(2);
   localparam logic [opc_width-1:0] OPC_AND = opc_width'(3);
   localparam logic [opc_width-1:0] OPC_XOR = opc_width'(4);
   localparam logic [opc_width-1:0] OPC_LDA = opc_width'(5);
   localparam logic [opc_width-1:0] OPC_STO = opc_width'(6);
   localparam logic [opc_width-1:0] OPC_JMP = opc_width'(7);

   phase_e phase_q, phase_d;
   logic   halted_q, halted_d;
   logic   is_hlt, is_alu, is_sto, is_jmp, is_skz, stall;

   assign is_hlt = (opcode == OPC_HLT);
   assign is_skz = (opcode == OPC_SKZ);
   assign is_sto = (opcode == OPC_STO);
   assign is_jmp = (opcode == OPC_JMP);
   assign is_alu = (opcode == OPC_ADD) || (opcode == OPC_AND) ||
                   (opcode == OPC_XOR) || (opcode == OPC_LDA);

   // Memory wait only applies to the two read phases; tied off when disabled.
   assign stall = mem_wait_en && !mem_ready &&
                  ((phase_q == PH_INST_FETCH) || (phase_q == PH_OP_FETCH));

   // State register: phase and sticky halted flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q  <= PH_INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   // Next state: halted holds, HLT in OP_ADDR latches halted, stalls hold, else advance.
   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      if (halted_q) begin
         phase_d = phase_q;
      end else if ((phase_q == PH_OP_ADDR) && is_hlt) begin
         halted_d = 1'b1;
      end else if (!stall) begin
         phase_d = phase_e'(3'(phase_q + 3'd1));
      end
   end

   // Output decode, purely combinational so reset clears strobes without a clock.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = halted_q;
      case (phase_q)
         PH_INST_ADDR: begin
            sel = 1'b1;
         end
         PH_INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         PH_INST_LOAD, PH_IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         PH_OP_ADDR: begin
            inc_pc = !is_hlt && !halted_q;
            halt   = is_hlt || halted_q;
         end
         PH_OP_FETCH: begin
            rd = is_alu;
         end
         PH_ALU_OP: begin
            rd     = is_alu;
            inc_pc = is_skz && zero;
            ld_pc  = is_jmp;
            data_e = is_sto;
         end
         PH_STORE: begin
            rd     = is_alu;
            ld_pc  = is_jmp;
            ld_ac  = is_alu;
            data_e = is_sto;
            wr     = is_sto;
         end
      endcase
   end

   assign phase = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: two instances (memory wait on / off) share stimulus
// and are compared every cycle against a behavioural phase/halt model.
module tb_cpu_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] opcode = 3'd2;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;

   logic sel_a, rd_a, ld_ir_a, inc_pc_a, ld_pc_a, ld_ac_a, wr_a, data_e_a, halt_a;
   logic sel_b, rd_b, ld_ir_b, inc_pc_b, ld_pc_b, ld_ac_b, wr_b, data_e_b, halt_b;
   logic [2:0] phase_a, phase_b;

   int checks = 0;
   int failures = 0;

   int m_ph[2];
   bit m_hl[2];
   bit wait_en[2] = '{1'b1, 1'b0};

   always #5 clk = ~clk;

   cpu_sequencer #(.opc_width(3), .mem_wait_en(1'b1)) u_dut_a (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .sel(sel_a), .rd(rd_a), .ld_ir(ld_ir_a), .inc_pc(inc_pc_a), .ld_pc(ld_pc_a),
      .ld_ac(ld_ac_a), .wr(wr_a), .data_e(data_e_a), .halt(halt_a), .phase(phase_a)
   );

   cpu_sequencer #(.opc_width(3), .mem_wait_en(1'b0)) u_dut_b (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .sel(sel_b), .rd(rd_b), .ld_ir(ld_ir_b), .inc_pc(inc_pc_b), .ld_pc(ld_pc_b),
      .ld_ac(ld_ac_b), .wr(wr_b), .data_e(data_e_b), .halt(halt_b), .phase(phase_b)
   );

   wire [11:0] obs_a = {sel_a, rd_a, ld_ir_a, inc_pc_a, ld_pc_a, ld_ac_a, wr_a, data_e_a, halt_a, phase_a};
   wire [11:0] obs_b = {sel_b, rd_b, ld_ir_b, inc_pc_b, ld_pc_b, ld_ac_b, wr_b, data_e_b, halt_b, phase_b};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Expected strobes from the phase/opcode rules, packed like obs_a/obs_b.
   function automatic logic [11:0] exp_out(int ph, bit hl, int op, bit z);
      bit alu, e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt;
      logic [2:0] p3;
      alu    = (op >= 2) && (op <= 5);
      e_sel  = (ph < 4);
      e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
      e_ldir = (ph == 2) || (ph == 3);
      e_inc  = (ph == 4 && op != 0 && !hl) || (ph == 6 && op == 1 && z);
      e_ldpc = (ph >= 6) && (op == 7);
      e_ldac = (ph == 7) && alu;
      e_de   = (ph >= 6) && (op == 6);
      e_wr   = (ph == 7) && (op == 6);
      e_halt = hl || (ph == 4 && op == 0);
      p3     = ph[2:0];
      return {e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt, p3};
   endfunction

   task automatic check_outputs();
      chk($sformatf("out_a ph%0d op%0d", m_ph[0], opcode), {20'd0, obs_a},
          {20'd0, exp_out(m_ph[0], m_hl[0], int'(opcode), zero)});
      chk($sformatf("out_b ph%0d op%0d", m_ph[1], opcode), {20'd0, obs_b},
          {20'd0, exp_out(m_ph[1], m_hl[1], int'(opcode), zero)});
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            m_ph[i] = 0;
            m_hl[i] = 1'b0;
         end else if (m_hl[i]) begin
            m_ph[i] = m_ph[i];
         end else if (m_ph[i] == 4 && opcode == 3'd0) begin
            m_hl[i] = 1'b1;
         end else if ((m_ph[i] == 1 || m_ph[i] == 5) && wait_en[i] && !mem_ready) begin
            m_ph[i] = m_ph[i];
         end else begin
            m_ph[i] = (m_ph[i] + 1) % 8;
         end
      end
   endtask

   // One clock: check outputs mid-cycle, advance model at the edge, return at edge+1.
   task automatic step();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // Async reset mid-cycle: strobes must clear with no clock edge.
   task automatic rst_pulse();
      rst = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         m_ph[i] = 0;
         m_hl[i] = 1'b0;
      end
      chk("async_rst_a", {20'd0, obs_a}, {20'd0, exp_out(0, 1'b0, int'(opcode), zero)});
      chk("async_rst_b", {20'd0, obs_b}, {20'd0, exp_out(0, 1'b0, int'(opcode), zero)});
      #2;
      rst = 1'b1;
   endtask

   task automatic seek_phase_a(input int target);
      for (int k = 0; k < 20 && m_ph[0] != target; k++) step();
      chk($sformatf("seek_ph%0d", target), m_ph[0], target);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_ph[i] = 0;
         m_hl[i] = 1'b0;
      end
      #3;
      chk("reset_a", {20'd0, obs_a}, {20'd0, 12'b1000_0000_0000});
      chk("reset_b", {20'd0, obs_b}, {20'd0, 12'b1000_0000_0000});
      run(2);
      rst = 1'b1;

      // Straight-line instructions, each aligned to phase 0.
      opcode = 3'd2; mem_ready = 1'b1; run(16);
      chk("wrap_ph_a", phase_a, 3'd0);
      opcode = 3'd6; run(8);
      opcode = 3'd1; zero = 1'b1; run(8);
      opcode = 3'd1; zero = 1'b0; run(8);
      opcode = 3'd7; run(8);

      // Instruction-fetch stall.
      opcode = 3'd2;
      seek_phase_a(1);
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall1_ph", phase_a, 3'd1);
         chk("stall1_rd", rd_a, 1'b1);
      end
      mem_ready = 1'b1;
      step();
      chk("stall1_adv", phase_a, 3'd2);

      // Operand-fetch stall with LDA.
      opcode = 3'd5;
      seek_phase_a(5);
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall5_ph", phase_a, 3'd5);
         chk("stall5_rd", rd_a, 1'b1);
      end
      mem_ready = 1'b1;
      step();
      chk("stall5_adv", phase_a, 3'd6);

      // Halt, hold for 20 clocks with random mem_ready, then async reset.
      opcode = 3'd0;
      seek_phase_a(4);
      for (int k = 0; k < 20; k++) begin
         mem_ready = 1'($urandom_range(0, 1));
         step();
      end
      chk("halt_hold_ph", phase_a, 3'd4);
      chk("halt_hold_halt", halt_a, 1'b1);
      chk("halt_hold_inc", inc_pc_a, 1'b0);
      opcode = 3'd2;
      chk("halted_ignores_op", halt_a, 1'b1);
      rst_pulse();
      chk("rst_ph_a", phase_a, 3'd0);
      chk("rst_halt_a", halt_a, 1'b0);
      mem_ready = 1'b1;
      run(4);

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 39) == 0) rst_pulse();
         opcode    = 3'($urandom_range(0, 7));
         zero      = 1'($urandom_range(0, 1));
         mem_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Eight-phase instruction sequencer for the 8-bit accumulator CPU.
- Each cycle it decodes the current phase, the 3-bit opcode from the instruction register and the accumulator zero flag.
- From these it drives the strobes for:
  - the program counter (load / increment),
  - the instruction register and accumulator,
  - the address mux and the memory read/write/data-enable lines.
- It sits between the instruction register and every datapath register, and owns the fetch/execute schedule.

Parameters:
- opc_width, 3, opcode field width; only 3 is supported.
- mem_wait_en, 1, 1 = fetch phases stall on mem_ready; 0 = mem_ready ignored (treated as 1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- opcode  in  opc_width  instruction-register opcode field
- zero  in  1  accumulator == 0 flag
- mem_ready  in  1  memory read data valid this cycle
- sel  out  1  address mux: 1 = PC address, 0 = IR operand address
- rd  out  1  memory read enable
- ld_ir  out  1  instruction-register load
- inc_pc  out  1  PC increment enable
- ld_pc  out  1  PC load (from IR operand)
- ld_ac  out  1  accumulator load
- wr  out  1  memory write strobe
- data_e  out  1  accumulator-to-data-bus drive enable
- halt  out  1  processor halted
- phase  out  3  current phase (debug)

Behaviour:
- Opcodes:
  - HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
  - aluop = ADD|AND|XOR|LDA.
- Phases:
  - 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE,
  - 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- State:
  - 3-bit phase register plus 1-bit halted register.
- Reset (rst=0, asynchronous):
  - phase=0, halted=0.
  - Outputs then decode phase 0: sel=1, every other strobe 0, halt=0.
- Phase advance at each clk edge, in priority order:
  1. Halted: phase holds.
  2. Stall: phase is 1 or 5, mem_wait_en=1 and mem_ready=0 → phase holds.
  3. Otherwise phase+1, wrapping 7→0.
- Halt:
  - Entering phase 4 with opcode=HLT sets halted at that edge's exit; phase stays 4.
  - Halted persists until reset; opcode and mem_ready are ignored while halted.
- Output decode: combinational from phase, opcode, zero and halted. No output is registered.
  - sel=1 in phases 0–3.
  - rd=1 in phases 1,2,3; rd=aluop in phases 5,6,7.
  - ld_ir=1 in phases 2,3.
  - halt=1 when phase=4 and opcode=HLT, or when halted=1.
  - inc_pc:
    - 1 in phase 4 when opcode≠HLT and not halted;
    - in phase 6, 1 when opcode=SKZ and zero=1;
    - 0 otherwise.
  - ld_pc=1 in phases 6,7 when opcode=JMP.
  - ld_ac=1 in phase 7 when aluop.
  - data_e=1 in phases 6,7 when opcode=STO.
  - wr=1 in phase 7 when opcode=STO.
- Stalled cycles: outputs stay at that phase's decode, so rd holds high through the wait.
- Implied PC behaviour:
  - PC increments once per instruction (phase 4).
  - SKZ with zero=1 gives a second increment (skip).
  - JMP: ld_pc in phases 6–7 overrides any increment, because the counter gives load priority over enable.
- Mid-instruction reset: every strobe drops in the same cycle rst falls, with no clock edge needed. The sequence restarts at phase 0.
- No output may glitch high because of opcode changes outside phases 2–3. The IR is stable from phase 3 onward.
- Out-of-range opcode is impossible (3 bits), so there is no default state.

Test Plan:
- Reset, then free-run with mem_ready=1 and opcode=ADD → phase steps 0..7 and wraps to 0 after 8 clocks.
  - rd is high in phases 1,2,3,5,6,7.
  - ld_ir is high in phases 2–3.
  - inc_pc pulses once, in phase 4.
  - ld_ac is high in phase 7.
  - wr and data_e stay 0.
- opcode=STO → rd=0 in phases 5–7; data_e=1 in phases 6–7; wr=1 only in phase 7; ld_ac never asserts.
- SKZ:
  - with zero=1 → inc_pc high in both phase 4 and phase 6;
  - with zero=0 → inc_pc high only in phase 4.
- opcode=JMP → ld_pc=1 in phases 6 and 7; inc_pc in phase 4 only.
- opcode=HLT at phase 4 → halt=1 and inc_pc=0; phase stays 4 for 20 clocks regardless of mem_ready.
  - Then pulse rst low → phase=0 and halt=0 immediately, with no clock edge needed.
- mem_wait_en=1, mem_ready=0 for 3 cycles in phase 1, then mem_ready=1 → phase holds 1 for 3 clocks with rd=1, then advances to 2.
  - Repeat the same stall in phase 5 with opcode=LDA.
  - With mem_wait_en=0 the same stimulus gives no stall.
